// File: rtl/timer.sv
// 32-bit programmable timer/counter bus slave: prescaled tick, compare match,
// overflow flag, optional auto-reload / one-shot, level interrupt.
module timer #(
  parameter int unsigned PRESCALE_WIDTH = 16,
  parameter logic [31:0] COMPARE_RST    = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  timer_address,
  input  logic [31:0] timer_data_i,
  input  logic [3:0]  timer_wr,
  input  logic        timer_enable,
  output logic [31:0] timer_data_o,
  output logic        timer_ready,
  output logic        timer_interrupt
);

  localparam logic [4:0] ADDR_CTRL     = 5'h00;
  localparam logic [4:0] ADDR_PRESCALE = 5'h04;
  localparam logic [4:0] ADDR_COUNT    = 5'h08;
  localparam logic [4:0] ADDR_COMPARE  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS   = 5'h10;

  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_IE = 1;
  localparam int unsigned CTRL_AR = 2;
  localparam int unsigned CTRL_OS = 3;

  // Architectural registers
  logic [3:0]                r_ctrl;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] r_pre_cnt;
  logic [31:0]               r_count;
  logic [31:0]               r_compare;
  logic [1:0]                r_status;
  logic                      r_ready;
  logic [31:0]               r_data_o;
  logic                      r_irq;

  // Bus decode
  logic [4:0]  w_addr;
  logic        w_accept;
  logic        w_wr;
  logic [31:0] w_mask;
  logic        w_wr_ctrl;
  logic        w_wr_prescale;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic [31:0] w_rdata;

  // Timer events
  logic        w_tick;
  logic        w_tick_eval;
  logic        w_match;
  logic        w_reload;
  logic        w_ovf;
  logic [1:0]  w_clr;

  // Bits [1:0] are don't-care: decoding on the word-aligned address keeps every
  // address bit in the compare while ignoring the byte lane.
  assign w_addr   = timer_address & 5'b11100;
  assign w_accept = timer_enable & ~r_ready;
  assign w_wr     = w_accept & (|timer_wr);
  assign w_mask   = {{8{timer_wr[3]}}, {8{timer_wr[2]}},
                     {8{timer_wr[1]}}, {8{timer_wr[0]}}};

  assign w_wr_ctrl     = w_wr & (w_addr == ADDR_CTRL);
  assign w_wr_prescale = w_wr & (w_addr == ADDR_PRESCALE);
  assign w_wr_count    = w_wr & (w_addr == ADDR_COUNT);
  assign w_wr_compare  = w_wr & (w_addr == ADDR_COMPARE);
  assign w_wr_status   = w_wr & (w_addr == ADDR_STATUS);

  // NOTE: every output of a combinational block gets a default before the case;
  // a missing branch would otherwise infer a latch.
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      ADDR_CTRL:     w_rdata = {28'd0, r_ctrl};
      ADDR_PRESCALE: w_rdata = {{(32-PRESCALE_WIDTH){1'b0}}, r_prescale};
      ADDR_COUNT:    w_rdata = r_count;
      ADDR_COMPARE:  w_rdata = r_compare;
      ADDR_STATUS:   w_rdata = {30'd0, r_status};
      default:       w_rdata = '0;
    endcase
  end

  // A software COUNT write in the tick cycle suppresses match/overflow evaluation.
  assign w_tick      = r_ctrl[CTRL_EN] & (r_pre_cnt == r_prescale);
  assign w_tick_eval = w_tick & ~w_wr_count;
  assign w_match     = w_tick_eval & (r_count == r_compare);
  assign w_reload    = w_match & r_ctrl[CTRL_AR];
  assign w_ovf       = w_tick_eval & ~w_reload & (r_count == 32'hFFFF_FFFF);
  assign w_clr       = w_wr_status ? (timer_data_i[1:0] & w_mask[1:0]) : 2'b00;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl <= '0;
    end else if (w_wr_ctrl) begin
      r_ctrl <= (r_ctrl & ~w_mask[3:0]) | (timer_data_i[3:0] & w_mask[3:0]);
    end else if (w_match && r_ctrl[CTRL_OS]) begin
      r_ctrl[CTRL_EN] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescale <= '0;
    end else if (w_wr_prescale) begin
      r_prescale <= (r_prescale & ~w_mask[PRESCALE_WIDTH-1:0])
                  | (timer_data_i[PRESCALE_WIDTH-1:0] & w_mask[PRESCALE_WIDTH-1:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_cnt <= '0;
    end else if (w_wr_count) begin
      r_pre_cnt <= '0;
    end else if (r_ctrl[CTRL_EN]) begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRESCALE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_wr_count) begin
      r_count <= (r_count & ~w_mask) | (timer_data_i & w_mask);
    end else if (w_tick) begin
      r_count <= w_reload ? 32'd0 : r_count + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_compare <= COMPARE_RST;
    end else if (w_wr_compare) begin
      r_compare <= (r_compare & ~w_mask) | (timer_data_i & w_mask);
    end
  end

  // Hardware set is OR-ed after the W1C clear so a same-cycle set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~w_clr) | {w_ovf, w_match};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready  <= 1'b0;
      r_data_o <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_ready  <= w_accept;
      r_data_o <= w_accept ? w_rdata : 32'd0;
      r_irq    <= (|r_status) & r_ctrl[CTRL_IE];
    end
  end

  assign timer_data_o    = r_data_o;
  assign timer_ready     = r_ready;
  assign timer_interrupt = r_irq;

endmodule

// File: tb/tb_timer.sv
// Scoreboard bench for timer: directed scenarios plus random bus traffic,
// checked against a cycle-level reference model built from the register rules.
module tb_timer;

  logic        clk;
  logic        rst;
  logic [4:0]  timer_address;
  logic [31:0] timer_data_i;
  logic [3:0]  timer_wr;
  logic        timer_enable;
  logic [31:0] timer_data_o;
  logic        timer_ready;
  logic        timer_interrupt;

  timer dut (
    .clk             (clk),
    .rst             (rst),
    .timer_address   (timer_address),
    .timer_data_i    (timer_data_i),
    .timer_wr        (timer_wr),
    .timer_enable    (timer_enable),
    .timer_data_o    (timer_data_o),
    .timer_ready     (timer_ready),
    .timer_interrupt (timer_interrupt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [3:0]  m_ctrl;
  logic [15:0] m_pres, m_pre;
  logic [31:0] m_count, m_cmp;
  logic [1:0]  m_stat;
  bit          m_ready, m_irq;
  logic [31:0] exp_q[$];
  bit          ov_en;
  logic [31:0] ov_val;

  function automatic logic [31:0] m_read(input logic [2:0] idx);
    case (idx)
      3'd0:    return {28'd0, m_ctrl};
      3'd1:    return {16'd0, m_pres};
      3'd2:    return m_count;
      3'd3:    return m_cmp;
      3'd4:    return {30'd0, m_stat};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin : ref_model
    logic        acc, wr, tick, carry;
    logic [2:0]  idx;
    logic [31:0] bm, n_count, n_cmp;
    logic [3:0]  n_ctrl;
    logic [15:0] n_pres, n_pre;
    logic [1:0]  setb, clrb;
    if (rst) begin
      m_ctrl = 0; m_pres = 0; m_pre = 0; m_count = 0;
      m_cmp = 32'hFFFF_FFFF; m_stat = 0; m_ready = 0; m_irq = 0;
      exp_q.delete();
    end else begin
      acc = timer_enable && !m_ready;
      wr  = acc && (timer_wr != 4'b0000);
      idx = timer_address[4:2];
      if (acc) exp_q.push_back(ov_en ? ov_val : m_read(idx));
      bm = {{8{timer_wr[3]}}, {8{timer_wr[2]}}, {8{timer_wr[1]}}, {8{timer_wr[0]}}};
      n_ctrl = m_ctrl; n_pres = m_pres; n_pre = m_pre;
      n_count = m_count; n_cmp = m_cmp; setb = 0; clrb = 0;
      // timer progress
      tick = m_ctrl[0] && (m_pre == m_pres);
      if (m_ctrl[0]) n_pre = tick ? 16'd0 : m_pre + 16'd1;
      if (tick && !(wr && idx == 3'd2)) begin
        if (m_count == m_cmp) begin
          setb[0] = 1'b1;
          if (m_ctrl[3]) n_ctrl[0] = 1'b0;
        end
        if (m_count == m_cmp && m_ctrl[2]) begin
          n_count = 0;
        end else begin
          {carry, n_count} = {1'b0, m_count} + 33'd1;
          if (carry) setb[1] = 1'b1;
        end
      end
      // software writes override hardware updates
      if (wr) begin
        case (idx)
          3'd0: n_ctrl  = (m_ctrl & ~bm[3:0]) | (timer_data_i[3:0] & bm[3:0]);
          3'd1: n_pres  = (m_pres & ~bm[15:0]) | (timer_data_i[15:0] & bm[15:0]);
          3'd2: begin
            n_count = (m_count & ~bm) | (timer_data_i & bm);
            n_pre   = 16'd0;
          end
          3'd3: n_cmp   = (m_cmp & ~bm) | (timer_data_i & bm);
          3'd4: clrb    = timer_data_i[1:0] & bm[1:0];
          default: ;
        endcase
      end
      m_irq   = m_ctrl[1] && (m_stat != 2'b00);
      m_ready = acc;
      m_ctrl = n_ctrl; m_pres = n_pres; m_pre = n_pre;
      m_count = n_count; m_cmp = n_cmp;
      m_stat = (m_stat & ~clrb) | setb;
    end
  end

  // Monitor: compares outputs every cycle and pops the scoreboard on ready
  initial begin
    while (!done) begin
      @(negedge clk);
      check("ready", {31'd0, timer_ready}, {31'd0, m_ready});
      check("irq", {31'd0, timer_interrupt}, {31'd0, m_irq});
      if (timer_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_ready: got ready with data %h, expected no response", timer_data_o);
        end else begin
          check("rdata", timer_data_o, exp_q.pop_front());
        end
      end
    end
  end

  task automatic bus(input logic [4:0] a, input logic [3:0] w, input logic [31:0] d,
                     input bit ov, input logic [31:0] ovv);
    @(negedge clk);
    timer_address = a; timer_wr = w; timer_data_i = d;
    timer_enable = 1'b1; ov_en = ov; ov_val = ovv;
    @(negedge clk);
    timer_enable = 1'b0; ov_en = 1'b0;
  endtask

  task automatic wr32(input logic [4:0] a, input logic [31:0] d);
    bus(a, 4'hF, d, 1'b0, 32'd0);
  endtask

  task automatic rd_exp(input logic [4:0] a, input logic [31:0] e);
    bus(a, 4'h0, 32'd0, 1'b1, e);
  endtask

  task automatic rd_model(input logic [4:0] a);
    bus(a, 4'h0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    bit found;
    rst = 1'b1; timer_enable = 0; timer_address = 0; timer_wr = 0;
    timer_data_i = 0; ov_en = 0; ov_val = 0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, timer_ready}, 32'd0);
    check("reset_data", timer_data_o, 32'd0);
    rst = 1'b0;

    // Reset values of every offset
    rd_exp(5'h00, 32'h0);
    rd_exp(5'h04, 32'h0);
    rd_exp(5'h08, 32'h0);
    rd_exp(5'h0C, 32'hFFFF_FFFF);
    rd_exp(5'h10, 32'h0);
    rd_exp(5'h14, 32'h0);
    rd_exp(5'h18, 32'h0);
    rd_exp(5'h1F, 32'h0);

    // Auto-reload periodic match with interrupt
    wr32(5'h04, 32'd3);
    wr32(5'h0C, 32'd4);
    wr32(5'h00, 32'h7);
    repeat (20) rd_model(5'h08);
    wr32(5'h10, 32'h1);
    rd_model(5'h10);
    repeat (10) @(negedge clk);

    // Overflow wrap
    wr32(5'h00, 32'h0);
    wr32(5'h10, 32'h3);
    wr32(5'h04, 32'h0);
    wr32(5'h0C, 32'd100);
    wr32(5'h08, 32'hFFFF_FFFE);
    wr32(5'h00, 32'h3);
    rd_exp(5'h08, 32'hFFFF_FFFF);
    rd_exp(5'h10, 32'h2);

    // One-shot
    wr32(5'h00, 32'h0);
    wr32(5'h10, 32'h3);
    wr32(5'h0C, 32'd10);
    wr32(5'h08, 32'd0);
    wr32(5'h00, 32'h9);
    repeat (20) @(negedge clk);
    rd_exp(5'h00, 32'h8);
    rd_exp(5'h08, 32'd11);
    rd_exp(5'h10, 32'h1);

    // Byte write
    wr32(5'h0C, 32'h1234_5678);
    bus(5'h0C, 4'b0010, 32'h0000_AB00, 1'b0, 32'd0);
    rd_exp(5'h0C, 32'h1234_AB78);

    // W1C colliding with the match edge: set wins
    wr32(5'h00, 32'h0);
    wr32(5'h10, 32'h3);
    wr32(5'h08, 32'd0);
    wr32(5'h0C, 32'd5);
    wr32(5'h00, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (m_ctrl[0] && m_pre == m_pres && m_count == m_cmp && !m_ready) begin
        found = 1'b1;
        timer_address = 5'h10; timer_wr = 4'hF; timer_data_i = 32'h1; timer_enable = 1'b1;
        @(negedge clk);
        timer_enable = 1'b0;
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL w1c_collision: match edge not reached within 50 cycles");
    end
    rd_exp(5'h10, 32'h1);
    wr32(5'h10, 32'h1);
    rd_exp(5'h10, 32'h0);

    // Random traffic, including enable held through ready
    repeat (500) begin
      @(negedge clk);
      timer_enable  = ($urandom_range(0, 9) < 6);
      timer_address = 5'($urandom);
      case ($urandom_range(0, 3))
        0:       timer_wr = 4'h0;
        1:       timer_wr = 4'hF;
        default: timer_wr = 4'($urandom);
      endcase
      timer_data_i = $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) : $urandom;
    end
    @(negedge clk);
    timer_enable = 1'b0;
    wr32(5'h00, 32'h7);
    repeat (3) @(negedge clk);

    // Reset in the middle of an access, enable held
    @(negedge clk);
    timer_address = 5'h0C; timer_wr = 4'h0; timer_enable = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, timer_ready}, 32'd0);
    check("midrst_data", timer_data_o, 32'd0);
    check("midrst_irq", {31'd0, timer_interrupt}, 32'd0);
    repeat (2) @(negedge clk);
    ov_en = 1'b1; ov_val = 32'hFFFF_FFFF;
    rst = 1'b0;
    @(negedge clk);
    timer_enable = 1'b0; ov_en = 1'b0;
    rd_exp(5'h00, 32'h0);
    rd_exp(5'h04, 32'h0);
    rd_exp(5'h08, 32'h0);
    rd_exp(5'h10, 32'h0);

    repeat (3) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/timer.md
Name: timer

Overview:
- 32-bit programmable timer/counter peripheral for the SoC bus.
- Hangs off the slave side of the address mux_switch as a new slave, at MATCH_ADDR 32'h1200_0000 with MATCH_MASK 32'hFFFF_FFE0.
- Drives one extra core interrupt line, concatenated above uart_rx_ready_int.
- Provides periodic ticks or one-shot delays for firmware, clocked on clk_bus.

Parameters:
- PRESCALE_WIDTH, 16, width of the prescaler divider register and counter.
- COMPARE_RST, 32'hFFFF_FFFF, reset value of the COMPARE register.

Ports:
- clk  input  1  bus clock (clk_bus).
- rst  input  1  reset; asynchronous, active-high.
- timer_address  input  5  byte address within the 32-byte window; bits [4:2] select the register, bits [1:0] are ignored.
- timer_data_i  input  32  write data.
- timer_wr  input  4  byte write enables; 4'b0000 = read.
- timer_enable  input  1  access request from mux_switch.
- timer_data_o  output  32  read data, valid while timer_ready=1.
- timer_ready  output  1  access-complete pulse.
- timer_interrupt  output  1  level interrupt to core.

Behaviour:
- Reset (asynchronous, active-high). All of the following are forced while rst=1:
  - CTRL=0, PRESCALE=0, COUNT=0, COMPARE=COMPARE_RST.
  - STATUS=0, prescaler counter=0.
  - timer_ready=0, timer_data_o=0, timer_interrupt=0.
- Register map (word offsets):
  - 0x00 CTRL: bit0 EN, bit1 IE, bit2 AUTO_RELOAD, bit3 ONE_SHOT; other bits read 0.
  - 0x04 PRESCALE: [PRESCALE_WIDTH-1:0], upper bits read 0.
  - 0x08 COUNT.
  - 0x0C COMPARE.
  - 0x10 STATUS: bit0 MATCH, bit1 OVF; write-1-to-clear.
  - 0x14-0x1C: reserved; read 0, writes ignored, access still completes with ready.
- Handshake:
  - An access is accepted in the cycle where timer_enable=1 and timer_ready=0.
  - timer_ready rises the next cycle for exactly one cycle, with timer_data_o = the register value sampled at acceptance.
  - Single-cycle latency; no wait states; no error response.
  - If timer_enable is still high in the cycle ready is high, no second access is accepted (ready must deassert first).
  - timer_enable dropping while ready is pending does not cancel the access.
- Writes:
  - Byte-granular per timer_wr, applied at the acceptance edge.
  - A write to COUNT also clears the prescaler counter.
  - A STATUS write clears the bits where data=1.
- Prescaler and tick:
  - While EN=1, the prescaler counts 0..PRESCALE and produces a one-cycle tick when it equals PRESCALE, then restarts at 0.
  - PRESCALE=0 therefore ticks every cycle.
  - EN=0 freezes both the prescaler and COUNT.
- On a tick:
  - If COUNT==COMPARE: MATCH is set. COUNT loads 0 if AUTO_RELOAD=1, else COUNT+1.
  - If COUNT==32'hFFFF_FFFF and it increments: COUNT wraps to 0 and OVF is set.
  - If ONE_SHOT=1 and a match occurs: EN clears in the same cycle.
- Simultaneous events:
  - Hardware set of MATCH/OVF in the same cycle as a software W1C of that bit: set wins.
  - Software write to COUNT in the same cycle as a tick: the software value wins and no match is evaluated that cycle.
  - Software write to CTRL in the same cycle as a ONE_SHOT auto-clear: the software value wins.
- Interrupt:
  - timer_interrupt is registered: (MATCH & IE) | (OVF & IE), updated one cycle after the flag or IE changes.
  - Level stays high until cleared via STATUS or IE=0.
- Reset mid-access drops timer_ready immediately; the access is lost.

Test Plan:
- Reset, then read each offset 0x00..0x1C -> CTRL=0, PRESCALE=0, COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, reserved=0; every access gives a single ready pulse one cycle after enable.
- PRESCALE=3, COMPARE=4, CTRL=4'b0111 (EN, IE, AUTO_RELOAD):
  - COUNT follows 0,1,2,3,4,0,... advancing every 4 clocks.
  - MATCH sets on the tick where COUNT==4; timer_interrupt rises one cycle later.
  - Writing STATUS=1 clears it, and the interrupt falls next cycle.
- COUNT=32'hFFFF_FFFE, PRESCALE=0, CTRL=EN|IE -> COUNT wraps to 0 after 2 cycles, OVF=1, interrupt asserts.
- CTRL=EN|ONE_SHOT, COMPARE=10, PRESCALE=0 -> after the match, CTRL reads 4'b1000, COUNT holds at 11, MATCH=1.
- Byte write timer_wr=4'b0010, data 32'h0000_AB00 to COMPARE=32'h1234_5678 -> COMPARE reads 32'h1234_AB78.
- Force a W1C of MATCH on the exact match cycle -> MATCH remains 1.
- Assert rst mid-access with timer_enable held -> ready=0, all registers return to reset values asynchronously.
